// File: rtl/dct_pkg.sv
// Shared constants and bank-state encoding for the row DCT, the transpose
// buffer and the column DCT stages.
package dct_pkg;

  localparam int DCT_W        = 12;
  localparam int DCT_NCOEF    = 6;
  localparam int DCT_NROW     = 8;
  localparam int DCT_ROW_BITS = DCT_NCOEF * DCT_W;
  localparam int DCT_COL_BITS = DCT_NROW * DCT_W;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  function automatic logic bank_writable(input bank_state_e st);
    return (st == BANK_EMPTY) || (st == BANK_FILLING);
  endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One transpose bank: NROW x NCOEF coefficient registers written a row at a
// time and read back a column at a time.
module dct_tbuf_bank
  import dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [2:0]              wr_row,
  input  logic [DCT_ROW_BITS-1:0] wr_data,
  input  logic [2:0]              rd_col,
  output logic [DCT_COL_BITS-1:0] rd_data
);

  logic [DCT_W-1:0] mem_r [DCT_NROW][DCT_NCOEF];
  logic [DCT_COL_BITS-1:0] rd_data_s;

  // Row write port; z0 sits in the most significant lane of wr_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DCT_NROW; r++) begin
        for (int c = 0; c < DCT_NCOEF; c++) begin
          mem_r[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < DCT_NCOEF; c++) begin
        mem_r[wr_row][c] <= wr_data[(DCT_NCOEF-1-c)*DCT_W +: DCT_W];
      end
    end
  end

  // Column read mux; row 0 lands in the most significant lane.
  always_comb begin
    rd_data_s = '0;
    for (int r = 0; r < DCT_NROW; r++) begin
      if (rd_col < 3'(DCT_NCOEF)) begin
        rd_data_s[(DCT_NROW-1-r)*DCT_W +: DCT_W] = mem_r[r][rd_col];
      end else begin
        rd_data_s[(DCT_NROW-1-r)*DCT_W +: DCT_W] = '0;
      end
    end
  end

  assign rd_data = rd_data_s;

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong row-to-column transpose between the row and column DCT passes:
// one bank fills with rows while the other drains as columns.
module dct_transpose_buffer
  import dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DCT_ROW_BITS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DCT_COL_BITS-1:0] out_data,
  output logic [2:0]              out_col,
  output logic                    out_last
);

  localparam logic [2:0] LAST_ROW = 3'(DCT_NROW - 1);
  localparam logic [2:0] LAST_COL = 3'(DCT_NCOEF - 1);

  bank_state_e bank_st_r [2];
  bank_state_e bank_st_s [2];
  logic wr_bank_r, wr_bank_s, rd_bank_r, rd_bank_s;
  logic [2:0] row_cnt_r, row_cnt_s, col_cnt_r, col_cnt_s;
  logic in_ready_r, in_ready_s;
  logic out_valid_r, out_valid_s, out_last_r, out_last_s;
  logic [DCT_COL_BITS-1:0] out_data_r, out_data_s;
  logic [DCT_COL_BITS-1:0] bank_col_s [2];
  logic wr_fire_s, rd_fire_s, load_first_s, load_next_s, free_s;
  logic [2:0] rd_col_s;

  assign wr_fire_s    = in_valid && in_ready_r;
  assign rd_fire_s    = out_valid_r && out_ready;
  assign load_first_s = !out_valid_r && (bank_st_r[rd_bank_r] == BANK_FULL);
  assign load_next_s  = rd_fire_s && (col_cnt_r != LAST_COL);
  assign free_s       = rd_fire_s && (col_cnt_r == LAST_COL);
  assign rd_col_s     = load_first_s ? 3'd0 : (col_cnt_r + 3'd1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tbuf_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire_s && (wr_bank_r == 1'(b))),
      .wr_row  (row_cnt_r),
      .wr_data (in_data),
      .rd_col  (rd_col_s),
      .rd_data (bank_col_s[b])
    );
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st_r[0] <= BANK_EMPTY;
      bank_st_r[1] <= BANK_EMPTY;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      row_cnt_r    <= 3'd0;
      col_cnt_r    <= 3'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_last_r   <= 1'b0;
    end else begin
      bank_st_r[0] <= bank_st_s[0];
      bank_st_r[1] <= bank_st_s[1];
      wr_bank_r    <= wr_bank_s;
      rd_bank_r    <= rd_bank_s;
      row_cnt_r    <= row_cnt_s;
      col_cnt_r    <= col_cnt_s;
      in_ready_r   <= in_ready_s;
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      out_last_r   <= out_last_s;
    end
  end

  // Bank states, pointers and counters. Write and read events always target
  // different banks, so both can be honoured in the same cycle.
  always_comb begin
    bank_st_s[0] = bank_st_r[0];
    bank_st_s[1] = bank_st_r[1];
    wr_bank_s    = wr_bank_r;
    rd_bank_s    = rd_bank_r;
    row_cnt_s    = row_cnt_r;
    col_cnt_s    = col_cnt_r;
    if (wr_fire_s) begin
      row_cnt_s = row_cnt_r + 3'd1;
      if (row_cnt_r == LAST_ROW) begin
        bank_st_s[wr_bank_r] = BANK_FULL;
        wr_bank_s            = ~wr_bank_r;
      end else begin
        bank_st_s[wr_bank_r] = BANK_FILLING;
      end
    end else begin
      row_cnt_s = row_cnt_r;
    end
    if (load_first_s) begin
      bank_st_s[rd_bank_r] = BANK_DRAINING;
      col_cnt_s            = 3'd0;
    end else if (load_next_s) begin
      col_cnt_s = col_cnt_r + 3'd1;
    end else if (free_s) begin
      bank_st_s[rd_bank_r] = BANK_EMPTY;
      rd_bank_s            = ~rd_bank_r;
      col_cnt_s            = 3'd0;
    end else begin
      col_cnt_s = col_cnt_r;
    end
    // in_ready is decoded from next state so it never depends on out_ready combinationally.
    in_ready_s = bank_writable(bank_st_s[wr_bank_s]);
  end

  // Next values of the registered output column.
  always_comb begin
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    out_last_s  = out_last_r;
    if (load_first_s || load_next_s) begin
      out_valid_s = 1'b1;
      out_data_s  = bank_col_s[rd_bank_r];
      out_last_s  = (rd_col_s == LAST_COL);
    end else if (free_s) begin
      out_valid_s = 1'b0;
      out_last_s  = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_col   = col_cnt_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed and randomized checks of dct_transpose_buffer against a
// queue-based golden transpose.
module tb_dct_transpose_buffer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [71:0] in_data;
  logic [95:0] out_data;
  logic [2:0]  out_col;

  int total = 0;
  int bad = 0;
  int cols_out = 0;
  int rows_in = 0;

  typedef struct packed {
    logic [95:0] data;
    logic [2:0]  col;
  } col_t;

  logic [71:0] blk_q [$];
  col_t        exp_q [$];
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  dct_transpose_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pat_row(input int r);
    logic [71:0] v;
    v = '0;
    for (int c = 0; c < 6; c++) v[(5-c)*12 +: 12] = 12'(16*r + c);
    return v;
  endfunction

  function automatic logic [95:0] pat_col(input int c);
    logic [95:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) v[(7-r)*12 +: 12] = 12'(16*r + c);
    return v;
  endfunction

  function automatic logic [71:0] rnd_row();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  function automatic logic [71:0] special_row();
    logic [71:0] v;
    int sel;
    v = '0;
    for (int c = 0; c < 6; c++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) v[(5-c)*12 +: 12] = 12'h800;
      else if (sel == 1) v[(5-c)*12 +: 12] = 12'h7FF;
      else v[(5-c)*12 +: 12] = 12'($urandom());
    end
    return v;
  endfunction

  task automatic model_reset();
    blk_q.delete();
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  // One clock cycle: drive inputs, score the visible output, update the model.
  task automatic step(input logic iv, input logic [71:0] d, input logic ordy);
    col_t        e;
    logic        fi, fo;
    logic [95:0] col;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    if (prev_stall) chk("hold_valid", 96'(out_valid), 96'd1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 96'(out_valid), 96'd0);
      end else begin
        e = exp_q[0];
        chk("col_data", out_data, e.data);
        chk("col_idx", 96'(out_col), 96'(e.col));
        chk("col_last", 96'(out_last), 96'(e.col == 3'd5));
      end
    end
    fi = iv && in_ready;
    fo = out_valid && ordy;
    prev_stall = out_valid && !ordy;
    if (fo && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      cols_out++;
    end
    if (fi) begin
      blk_q.push_back(d);
      rows_in++;
      if (blk_q.size() == 8) begin
        for (int c = 0; c < 6; c++) begin
          col = '0;
          for (int r = 0; r < 8; r++) col[(7-r)*12 +: 12] = blk_q[r][(5-c)*12 +: 12];
          exp_q.push_back('{data: col, col: 3'(c)});
        end
        blk_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int pat, input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      step(1'b0, 72'd0, (pat == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3)));
      k++;
    end
    chk(tag, 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    int   c0, r0, target, cyc, k;
    logic pv, f5, done;
    logic [71:0] pend;
    rst = 1'b1; in_valid = 1'b0; in_data = 72'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 96'(in_ready), 96'd1);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_out_data", out_data, 96'd0);
    chk("rst_out_col", 96'(out_col), 96'd0);
    chk("rst_out_last", 96'(out_last), 96'd0);
    rst = 1'b0;

    // 1: single block, latency and consecutive drain
    c0 = cols_out;
    for (int r = 0; r < 8; r++) step(1'b1, pat_row(r), 1'b1);
    chk("lat_t", 96'(out_valid), 96'd0);
    step(1'b0, 72'd0, 1'b1);
    chk("lat_t1", 96'(out_valid), 96'd1);
    chk("first_col", out_data, pat_col(0));
    chk("first_idx", 96'(out_col), 96'd0);
    for (int i = 0; i < 6; i++) begin
      chk("consec_valid", 96'(out_valid), 96'd1);
      step(1'b0, 72'd0, 1'b1);
    end
    chk("t1_idle", 96'(out_valid), 96'd0);
    chk("t1_cols", 96'(cols_out - c0), 96'd6);

    // 2: back-pressure 1,0,0,1
    c0 = cols_out;
    for (int r = 0; r < 8; r++) step(1'b1, rnd_row(), 1'b1);
    drain(1, "t2_drain");
    chk("t2_cols", 96'(cols_out - c0), 96'd6);

    // 3: both banks full, in_ready recovery
    for (int r = 0; r < 16; r++) begin
      chk("fill_ready", 96'(in_ready), 96'd1);
      step(1'b1, rnd_row(), 1'b0);
    end
    chk("both_full", 96'(in_ready), 96'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 72'd0, 1'b0);
      chk("full_hold", 96'(in_ready), 96'd0);
    end
    done = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      f5 = out_valid && (exp_q.size() > 0) && (exp_q[0].col == 3'd5);
      chk("wait_ready", 96'(in_ready), 96'd0);
      step(1'b0, 72'd0, 1'b1);
      if (f5) begin
        done = 1'b1;
        chk("free_ready", 96'(in_ready), 96'd1);
      end
      k++;
    end
    chk("free_seen", 96'(done), 96'd1);
    drain(0, "t3_drain");

    // 4: continuous streaming with extreme signed values
    c0 = cols_out;
    for (int i = 0; i < 32; i++) begin
      chk("stream_ready", 96'(in_ready), 96'd1);
      step(1'b1, special_row(), 1'b1);
    end
    drain(0, "t4_drain");
    chk("stream_cols", 96'(cols_out - c0), 96'd24);

    // 5: reset mid-block discards partial and undrained data
    for (int r = 0; r < 8; r++) step(1'b1, rnd_row(), 1'b0);
    step(1'b1, rnd_row(), 1'b1);
    step(1'b1, rnd_row(), 1'b1);
    step(1'b1, rnd_row(), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 96'(out_valid), 96'd0);
    chk("arst_out_data", out_data, 96'd0);
    chk("arst_out_col", 96'(out_col), 96'd0);
    chk("arst_out_last", 96'(out_last), 96'd0);
    chk("arst_in_ready", 96'(in_ready), 96'd1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    c0 = cols_out;
    for (int r = 0; r < 8; r++) step(1'b1, pat_row(r + 1), 1'b1);
    drain(0, "t5_drain");
    chk("t5_cols", 96'(cols_out - c0), 96'd6);

    // 6: random gaps on both sides, 200 blocks
    target = rows_in + 1600;
    cyc = 0;
    pv = 1'b0;
    pend = 72'd0;
    while (rows_in < target && cyc < 30000) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pend = rnd_row();
      end
      r0 = rows_in;
      step(pv, pend, $urandom_range(0, 3) != 0);
      if (rows_in != r0) pv = 1'b0;
      cyc++;
    end
    chk("rand_rows", 96'(rows_in == target), 96'd1);
    drain(0, "t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
